// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: the queued write record and the source tag.
package h2bp;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_FUNC = 1'b0,
        WB_SRC_DATA = 1'b1
    } wb_src_e;

    // Round-robin pick between two heads; returns {grant_data, grant_func}.
    function automatic logic [1:0] wb_pick(input logic f_ne, input logic d_ne, input wb_src_e last);
        logic gf;
        logic gd;
        gf = f_ne && (!d_ne || (last == WB_SRC_DATA));
        gd = d_ne && (!f_ne || (last == WB_SRC_FUNC));
        return {gd, gf};
    endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Small synchronous FIFO of {addr,data} writeback records with per-slot valid bits,
// so the parent can see every queued destination register.
module wb_fifo
    import h2bp::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [ADDR_W-1:0]             push_addr_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    output logic [ADDR_W-1:0]             head_addr_o,
    output logic [DATA_W-1:0]             head_data_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [DEPTH-1:0]              ent_vld_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic push_ok;
    logic pop_ok;

    // Wrap by explicit compare so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Full/empty come from the registered count only, never from this cycle's pop.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign ent_vld_o   = vld_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_addr_o[i] = addr_q[i];
    end

    // Next-state for pointers, occupancy count and slot valid bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (push_ok) begin
            wr_ptr_d        = next_ptr(wr_ptr_q);
            vld_d[wr_ptr_q] = 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d        = next_ptr(rd_ptr_q);
            vld_d[rd_ptr_q] = 1'b0;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage; contents are only meaningful where the slot is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two queued sources share the single regfile write port,
// with round-robin on conflict, head bypass and a pending-register mask.
module wb_arbiter
    import h2bp::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   func_valid,
    output logic                   func_ready,
    input  logic [ADDR_W-1:0]      func_addr,
    input  logic [DATA_W-1:0]      func_data,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [ADDR_W-1:0]      data_addr,
    input  logic [DATA_W-1:0]      data_data,
    output logic                   result_enable,
    output logic [ADDR_W-1:0]      result_addr,
    output logic [DATA_W-1:0]      result,
    output logic [ADDR_W-1:0]      result_addr_func,
    output logic [DATA_W-1:0]      result_func,
    output logic [ADDR_W-1:0]      result_addr_data,
    output logic [DATA_W-1:0]      result_data,
    output logic [2**ADDR_W-1:0]   pending_mask
);

    logic                              f_empty, f_full, d_empty, d_full;
    logic [ADDR_W-1:0]                 f_head_addr, d_head_addr;
    logic [DATA_W-1:0]                 f_head_data, d_head_data;
    logic [BUF_DEPTH-1:0]              f_vld, d_vld;
    logic [BUF_DEPTH-1:0][ADDR_W-1:0]  f_addrs, d_addrs;
    logic                              grant_func, grant_data;
    wb_src_e                           last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]                 win_addr;
    logic [DATA_W-1:0]                 win_data;
    logic                              win_any;

    wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_func_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (func_valid),
        .push_addr_i (func_addr),
        .push_data_i (func_data),
        .pop_i       (grant_func),
        .head_addr_o (f_head_addr),
        .head_data_o (f_head_data),
        .empty_o     (f_empty),
        .full_o      (f_full),
        .ent_vld_o   (f_vld),
        .ent_addr_o  (f_addrs)
    );

    wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_data_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (data_valid),
        .push_addr_i (data_addr),
        .push_data_i (data_data),
        .pop_i       (grant_data),
        .head_addr_o (d_head_addr),
        .head_data_o (d_head_data),
        .empty_o     (d_empty),
        .full_o      (d_full),
        .ent_vld_o   (d_vld),
        .ent_addr_o  (d_addrs)
    );

    assign func_ready = !f_full;
    assign data_ready = !d_full;
    assign {grant_data, grant_func} = wb_pick(!f_empty, !d_empty, last_grant_q);

    // Winner mux; x0 heads are popped but never written, and reset masks the write.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_any  = grant_func || grant_data;
        if (grant_func) begin
            win_addr = f_head_addr;
            win_data = f_head_data;
        end else if (grant_data) begin
            win_addr = d_head_addr;
            win_data = d_head_data;
        end
        result_enable = rst_n && win_any && (win_addr != '0);
        result_addr   = result_enable ? win_addr : '0;
        result        = result_enable ? win_data : '0;
    end

    // Bypass each head; an empty queue reads as x0 = 0.
    always_comb begin
        result_addr_func = f_empty ? '0 : f_head_addr;
        result_func      = f_empty ? '0 : f_head_data;
        result_addr_data = d_empty ? '0 : d_head_addr;
        result_data      = d_empty ? '0 : d_head_data;
    end

    // Decode every queued destination into the hazard mask; x0 never stalls.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (f_vld[i]) pending_mask[f_addrs[i]] = 1'b1;
            if (d_vld[i]) pending_mask[d_addrs[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    // Only a real conflict moves the round-robin pointer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_func && !d_empty) last_grant_d = WB_SRC_FUNC;
        if (grant_data && !f_empty) last_grant_d = WB_SRC_DATA;
    end

    // Round-robin state; reset favours data on the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= WB_SRC_FUNC;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus burst and reset sequences.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        func_valid, data_valid;
    logic        func_ready, data_ready;
    logic [4:0]  func_addr, data_addr;
    logic [31:0] func_data, data_data;
    logic        result_enable;
    logic [4:0]  result_addr, result_addr_func, result_addr_data;
    logic [31:0] result, result_func, result_data;
    logic [31:0] pending_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_W(32), .ADDR_W(5), .BUF_DEPTH(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .func_valid       (func_valid),
        .func_ready       (func_ready),
        .func_addr        (func_addr),
        .func_data        (func_data),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .data_addr        (data_addr),
        .data_data        (data_data),
        .result_enable    (result_enable),
        .result_addr      (result_addr),
        .result           (result),
        .result_addr_func (result_addr_func),
        .result_func      (result_func),
        .result_addr_data (result_addr_data),
        .result_data      (result_data),
        .pending_mask     (pending_mask)
    );

    typedef struct {
        logic        fv;
        logic [4:0]  fa;
        logic [31:0] fd;
        logic        dv;
        logic [4:0]  da;
        logic [31:0] dd;
        logic        ren;
        logic [4:0]  raddr;
        logic [31:0] res;
        logic [4:0]  bfa;
        logic [31:0] bfd;
        logic [4:0]  bda;
        logic [31:0] bdd;
        logic [31:0] pm;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fv, input logic [4:0] fa, input logic [31:0] fd,
                                input logic dv, input logic [4:0] da, input logic [31:0] dd,
                                input logic ren, input logic [4:0] raddr, input logic [31:0] res,
                                input logic [4:0] bfa, input logic [31:0] bfd,
                                input logic [4:0] bda, input logic [31:0] bdd,
                                input logic [31:0] pm);
        vec_t v;
        v.fv = fv; v.fa = fa; v.fd = fd; v.dv = dv; v.da = da; v.dd = dd;
        v.ren = ren; v.raddr = raddr; v.res = res;
        v.bfa = bfa; v.bfd = bfd; v.bda = bda; v.bdd = bdd; v.pm = pm;
        return v;
    endfunction

    task automatic idle_inputs();
        func_valid = 1'b0; func_addr = '0; func_data = '0;
        data_valid = 1'b0; data_addr = '0; data_data = '0;
    endtask

    initial begin
        logic [4:0]  fq_a [4];
        logic [31:0] fq_d [4];
        logic [4:0]  dq_a [4];
        logic [31:0] dq_d [4];
        int fi, di, fw, dw;
        logic ffire, dfire;

        // Inputs are for the coming edge; expectations are observed just after it.
        vecs[0] = mk(1, 5'd5, 32'hDEADBEEF, 0, 0, 0,  1, 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF, 0, 0, 32'h0000_0020);
        vecs[1] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[2] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 5'd2, 32'h22, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0000_0006);
        vecs[3] = mk(0, 0, 0, 0, 0, 0,                 1, 5'd1, 32'h11, 5'd1, 32'h11, 0, 0, 32'h0000_0002);
        vecs[4] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[5] = mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1, 5'd3, 32'h33, 5'd3, 32'h33, 5'd4, 32'h44, 32'h0000_0018);
        vecs[6] = mk(0, 0, 0, 0, 0, 0,                 1, 5'd4, 32'h44, 0, 0, 5'd4, 32'h44, 32'h0000_0010);
        vecs[7] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[8] = mk(1, 5'd0, 32'h55, 0, 0, 0,         0, 0, 0, 5'd0, 32'h55, 0, 0, 32'h0);
        vecs[9] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Reset and idle
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ren_during", {31'b0, result_enable}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ren", {31'b0, result_enable}, 32'h0);
        chk("idle_fready", {31'b0, func_ready}, 32'h1);
        chk("idle_dready", {31'b0, data_ready}, 32'h1);
        chk("idle_pm", pending_mask, 32'h0);
        chk("idle_bfa", {27'b0, result_addr_func}, 32'h0);
        chk("idle_bda", {27'b0, result_addr_data}, 32'h0);
        chk("idle_res", result, 32'h0);

        // Table: single push, conflicts with alternation, x0 drop
        for (int i = 0; i < 10; i++) begin
            func_valid = vecs[i].fv; func_addr = vecs[i].fa; func_data = vecs[i].fd;
            data_valid = vecs[i].dv; data_addr = vecs[i].da; data_data = vecs[i].dd;
            @(posedge clk);
            #1;
            idle_inputs();
            chk($sformatf("v%0d_ren", i), {31'b0, result_enable}, {31'b0, vecs[i].ren});
            chk($sformatf("v%0d_raddr", i), {27'b0, result_addr}, {27'b0, vecs[i].raddr});
            chk($sformatf("v%0d_res", i), result, vecs[i].res);
            chk($sformatf("v%0d_bfa", i), {27'b0, result_addr_func}, {27'b0, vecs[i].bfa});
            chk($sformatf("v%0d_bfd", i), result_func, vecs[i].bfd);
            chk($sformatf("v%0d_bda", i), {27'b0, result_addr_data}, {27'b0, vecs[i].bda});
            chk($sformatf("v%0d_bdd", i), result_data, vecs[i].bdd);
            chk($sformatf("v%0d_pm", i), pending_mask, vecs[i].pm);
            chk($sformatf("v%0d_fready", i), {31'b0, func_ready}, 32'h1);
            chk($sformatf("v%0d_dready", i), {31'b0, data_ready}, 32'h1);
        end

        // Both sources saturated: func fills after two pushes, order kept per source
        fq_a[0] = 5'd6;  fq_a[1] = 5'd7;  fq_a[2] = 5'd8;  fq_a[3] = 5'd0;
        fq_d[0] = 32'hF6; fq_d[1] = 32'hF7; fq_d[2] = 32'hF8; fq_d[3] = 32'h0;
        dq_a[0] = 5'd9;  dq_a[1] = 5'd10; dq_a[2] = 5'd11; dq_a[3] = 5'd0;
        dq_d[0] = 32'hD9; dq_d[1] = 32'hDA; dq_d[2] = 32'hDB; dq_d[3] = 32'h0;
        fi = 0; di = 0; fw = 0; dw = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            func_valid = (fi < 3); func_addr = fq_a[fi]; func_data = fq_d[fi];
            data_valid = (di < 3); data_addr = dq_a[di]; data_data = dq_d[di];
            if (result_enable) begin
                if (result_addr >= 5'd6 && result_addr <= 5'd8) begin
                    if (fw < 3) begin
                        chk($sformatf("burst_f%0d_addr", fw), {27'b0, result_addr}, {27'b0, fq_a[fw]});
                        chk($sformatf("burst_f%0d_data", fw), result, fq_d[fw]);
                    end else begin
                        chk("burst_f_extra", 32'(fw), 32'd2);
                    end
                    fw++;
                end else begin
                    if (dw < 3) begin
                        chk($sformatf("burst_d%0d_addr", dw), {27'b0, result_addr}, {27'b0, dq_a[dw]});
                        chk($sformatf("burst_d%0d_data", dw), result, dq_d[dw]);
                    end else begin
                        chk("burst_d_extra", 32'(dw), 32'd2);
                    end
                    dw++;
                end
            end
            ffire = func_valid && func_ready;
            dfire = data_valid && data_ready;
            @(posedge clk);
            #1;
            if (ffire) fi++;
            if (dfire) di++;
            if (cyc == 1) chk("burst_fready_full", {31'b0, func_ready}, 32'h0);
            if (cyc == 2) chk("burst_fready_back", {31'b0, func_ready}, 32'h1);
        end
        idle_inputs();
        chk("burst_f_count", 32'(fw), 32'd3);
        chk("burst_d_count", 32'(dw), 32'd3);
        chk("burst_pm_drained", pending_mask, 32'h0);

        // Queue writes on both sides, then reset mid-operation
        for (int k = 0; k < 3; k++) begin
            func_valid = 1'b1; func_addr = 5'(12 + k); func_data = 32'hA0 + 32'(k);
            data_valid = 1'b1; data_addr = 5'(20 + k); data_data = 32'hB0 + 32'(k);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        chk("prerst_ren", {31'b0, result_enable}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("inrst_ren_forced", {31'b0, result_enable}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_ren", {31'b0, result_enable}, 32'h0);
        chk("postrst_fready", {31'b0, func_ready}, 32'h1);
        chk("postrst_dready", {31'b0, data_ready}, 32'h1);
        chk("postrst_pm", pending_mask, 32'h0);
        chk("postrst_bfa", {27'b0, result_addr_func}, 32'h0);
        chk("postrst_bda", {27'b0, result_addr_data}, 32'h0);
        @(posedge clk);
        #1;
        chk("postrst_ren_next", {31'b0, result_enable}, 32'h0);

        // First conflict after a reset goes to data again
        func_valid = 1'b1; func_addr = 5'd16; func_data = 32'hC1;
        data_valid = 1'b1; data_addr = 5'd17; data_data = 32'hC2;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("rr_reset_addr", {27'b0, result_addr}, 32'd17);
        chk("rr_reset_data", result, 32'hC2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
